// File: rtl/buffer_frame_reader.sv
// Read-side frame walker for the double buffer: issues credit-limited reads,
// realigns the returned words and streams them out with first/last markers.
module buffer_frame_reader #(
  parameter int ADDRESS_DEPTH = 8,
  parameter int BANK_COUNT    = 1,
  parameter int BANDWIDTH     = 8,
  parameter int READ_LATENCY  = 1,
  parameter int OUT_DEPTH     = 4,
  localparam int AW = (ADDRESS_DEPTH > 1) ? $clog2(ADDRESS_DEPTH) : 1,
  localparam int DW = BANDWIDTH * BANK_COUNT
) (
  input  logic                     clkb,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     data_valid,
  output logic [BANK_COUNT*AW-1:0] adb,
  output logic                     clk_data_out,
  input  logic [DW-1:0]            dout_flat,
  output logic [DW-1:0]            m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]           r_addr;
  logic [READ_LATENCY-1:0] r_dl_v;
  logic [READ_LATENCY-1:0] r_dl_f;
  logic [READ_LATENCY-1:0] r_dl_l;
  logic [DW+1:0]           r_mem [OUT_DEPTH];
  logic [PW-1:0]           r_wr;
  logic [PW-1:0]           r_rd;
  logic [CW-1:0]           r_count;
  logic                    r_frame_done;

  logic [IW-1:0] w_inflight;
  logic [DW+1:0] w_head;
  logic          w_credit;
  logic          w_issue;
  logic          w_addr_last;
  logic          w_push;
  logic          w_pop;
  logic          w_last_hs;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      w_inflight = w_inflight + IW'(r_dl_v[i]);
  end

  // Credit uses the pre-edge count: a slot freed this cycle is reusable next cycle
  assign w_credit    = (32'(r_count) + 32'(w_inflight)) < 32'(OUT_DEPTH);
  assign w_addr_last = (r_addr == AW'(ADDRESS_DEPTH - 1));
  assign w_push      = r_dl_v[READ_LATENCY-1];
  assign w_head      = r_mem[r_rd];
  assign m_valid     = (r_count != '0);
  assign w_pop       = m_valid && m_ready;
  assign w_last_hs   = w_pop && w_head[0];

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)                  w_next = S_WAIT;
      S_WAIT:  if (data_valid)             w_next = S_READ;
      S_READ:  if (w_issue && w_addr_last) w_next = S_DRAIN;
      S_DRAIN: if (w_last_hs)              w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != S_IDLE);
    w_issue      = (r_state == S_READ) && w_credit;
    clk_data_out = w_issue;
    adb          = w_issue ? {BANK_COUNT{r_addr}} : '0;
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (r_state == S_WAIT) begin
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= w_addr_last ? '0 : r_addr + AW'(1);
    end
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      r_dl_v <= '0;
      r_dl_f <= '0;
      r_dl_l <= '0;
    end else begin
      r_dl_v[0] <= w_issue;
      r_dl_f[0] <= (r_addr == '0);
      r_dl_l[0] <= w_addr_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_dl_v[i] <= r_dl_v[i-1];
        r_dl_f[i] <= r_dl_f[i-1];
        r_dl_l[i] <= r_dl_l[i-1];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (w_push)
      r_mem[r_wr] <= {dout_flat, r_dl_f[READ_LATENCY-1], r_dl_l[READ_LATENCY-1]};
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wr <= (r_wr == PW'(OUT_DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)
        r_rd <= (r_rd == PW'(OUT_DEPTH - 1)) ? '0 : r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) r_frame_done <= 1'b0;
    else     r_frame_done <= (r_state == S_DRAIN) && w_last_hs;
  end

  assign frame_done = r_frame_done;
  assign m_data     = m_valid ? w_head[DW+1:2] : '0;
  assign m_first    = m_valid && w_head[1];
  assign m_last     = m_valid && w_head[0];

endmodule

// File: tb/tb_buffer_frame_reader.sv
// Bench for buffer_frame_reader: behavioural buffer, port monitors and
// per-scenario tasks comparing each frame against the preloaded contents.
module tb_buffer_frame_reader;

  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_start, a_dv, a_cdo, a_mv, a_mr, a_mf, a_ml, a_busy, a_fd;
  logic [AW-1:0] a_adb;
  logic [7:0]    a_dout = 8'h00;
  logic [7:0]    a_md;
  logic [7:0]    a_mem [N];

  logic          b_start, b_dv, b_cdo, b_mv, b_mr, b_mf, b_ml, b_busy, b_fd;
  logic [AW-1:0] b_adb;
  logic [7:0]    b_p1 = 8'h00;
  logic [7:0]    b_dout = 8'h00;
  logic [7:0]    b_md;
  logic [7:0]    b_mem [N];

  buffer_frame_reader u_a (
    .clkb(clk), .rst(rst), .start(a_start), .data_valid(a_dv),
    .adb(a_adb), .clk_data_out(a_cdo), .dout_flat(a_dout),
    .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr),
    .m_first(a_mf), .m_last(a_ml), .busy(a_busy), .frame_done(a_fd)
  );

  buffer_frame_reader #(.READ_LATENCY(2), .OUT_DEPTH(3)) u_b (
    .clkb(clk), .rst(rst), .start(b_start), .data_valid(b_dv),
    .adb(b_adb), .clk_data_out(b_cdo), .dout_flat(b_dout),
    .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr),
    .m_first(b_mf), .m_last(b_ml), .busy(b_busy), .frame_done(b_fd)
  );

  // buffer read ports: latency 1 for A, latency 2 for B
  always @(posedge clk) if (a_cdo) a_dout <= a_mem[a_adb];
  always @(posedge clk) begin
    b_p1   <= b_mem[b_adb];
    b_dout <= b_p1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0] a_q[$];
  logic [9:0] b_q[$];
  int a_issued, a_acc, a_fdone, a_fd_busy, a_first_cdo, a_last_cdo, a_first_mv;
  int b_issued, b_acc, b_fdone, b_max_out, b_first_cdo, b_first_mv;

  always @(negedge clk) begin
    cyc++;
    if (a_cdo) begin
      a_issued++;
      if (a_first_cdo < 0) a_first_cdo = cyc;
      a_last_cdo = cyc;
    end
    if (a_mv && a_first_mv < 0) a_first_mv = cyc;
    if (a_mv && a_mr) begin
      a_q.push_back({a_md, a_mf, a_ml});
      a_acc++;
    end
    if (a_fd) begin
      a_fdone++;
      if (a_busy) a_fd_busy++;
    end
    if (b_cdo) begin
      b_issued++;
      if (b_first_cdo < 0) b_first_cdo = cyc;
    end
    if (b_issued - b_acc > b_max_out) b_max_out = b_issued - b_acc;
    if (b_mv && b_first_mv < 0) b_first_mv = cyc;
    if (b_mv && b_mr) begin
      b_q.push_back({b_md, b_mf, b_ml});
      b_acc++;
    end
    if (b_fd) b_fdone++;
  end

  task automatic clear_a();
    a_q.delete();
    a_issued = 0; a_acc = 0; a_fdone = 0; a_fd_busy = 0;
    a_first_cdo = -1; a_last_cdo = -1; a_first_mv = -1;
  endtask

  task automatic clear_b();
    b_q.delete();
    b_issued = 0; b_acc = 0; b_fdone = 0; b_max_out = 0;
    b_first_cdo = -1; b_first_mv = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic fill_a_random();
    for (int i = 0; i < N; i++) a_mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({a_mv, a_cdo, a_busy, a_fd, a_mf, a_ml, a_md, a_adb} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got %h want 0",
               {a_mv, a_cdo, a_busy, a_fd, a_mf, a_ml, a_md, a_adb});
    end
    n_checks++;
    if ({b_mv, b_cdo, b_busy, b_fd, b_mf, b_ml, b_md, b_adb} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got %h want 0",
               {b_mv, b_cdo, b_busy, b_fd, b_mf, b_ml, b_md, b_adb});
    end
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (a_busy !== 1'b0 || a_mv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b want 0 0", a_busy, a_mv);
    end
  endtask

  task automatic test_basic();
    int k;
    logic [9:0] exp;
    for (int i = 0; i < N; i++) a_mem[i] = 8'hA0 + 8'(i);
    clear_a();
    a_dv = 1'b1;
    a_mr = 1'b1;
    pulse_a();
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b want 1", a_busy);
    end
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    n_checks++;
    if (a_fdone == 0) begin
      n_fail++;
      $display("FAIL basic_timeout: frame_done count %0d want 1", a_fdone);
    end
    n_checks++;
    if (a_busy !== 1'b0 || a_fd !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: busy=%b done=%b want 0 0", a_busy, a_fd);
    end
    n_checks++;
    if (a_fd_busy != 0) begin
      n_fail++;
      $display("FAIL basic_done_busy: busy high with done %0d times want 0", a_fd_busy);
    end
    n_checks++;
    if (a_first_mv - a_first_cdo != 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 2", a_first_mv - a_first_cdo);
    end
    n_checks++;
    if (a_last_cdo - a_first_cdo != N - 1) begin
      n_fail++;
      $display("FAIL basic_throughput: read span %0d want %0d", a_last_cdo - a_first_cdo, N - 1);
    end
    n_checks++;
    if (a_q.size() != N) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want %0d", a_q.size(), N);
    end
    for (int i = 0; i < a_q.size() && i < N; i++) begin
      exp = {a_mem[i], i == 0, i == N - 1};
      n_checks++;
      if (a_q[i] !== exp) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h want %h", i, a_q[i], exp);
      end
    end
    repeat (3) step();
    n_checks++;
    if (a_fdone != 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: got %0d want 1", a_fdone);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int bad;
    logic [9:0] exp;
    clear_a();
    a_dv = 1'b1;
    a_mr = 1'b0;
    pulse_a();
    k = 0;
    while (!a_mv && k < 50) begin step(); k++; end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (a_mv !== 1'b1 || a_md !== 8'hA0 || a_mf !== 1'b1) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles want 0 (data %h)", bad, a_md);
    end
    n_checks++;
    if (a_issued != 4) begin
      n_fail++;
      $display("FAIL bp_credit: reads issued %0d want 4", a_issued);
    end
    a_mr = 1'b1;
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    n_checks++;
    if (a_q.size() != N || a_fdone != 1) begin
      n_fail++;
      $display("FAIL bp_count: words %0d done %0d want %0d 1", a_q.size(), a_fdone, N);
    end
    for (int i = 0; i < a_q.size() && i < N; i++) begin
      exp = {a_mem[i], i == 0, i == N - 1};
      n_checks++;
      if (a_q[i] !== exp) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h want %h", i, a_q[i], exp);
      end
    end
  endtask

  task automatic test_wait_valid();
    int k;
    logic [9:0] exp;
    fill_a_random();
    clear_a();
    a_dv = 1'b0;
    a_mr = 1'b1;
    pulse_a();
    repeat (20) step();
    n_checks++;
    if (a_issued != 0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_idle: reads %0d busy %b want 0 1", a_issued, a_busy);
    end
    a_dv = 1'b1;
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    n_checks++;
    if (a_q.size() != N || a_fdone != 1) begin
      n_fail++;
      $display("FAIL wait_count: words %0d done %0d want %0d 1", a_q.size(), a_fdone, N);
    end
    for (int i = 0; i < a_q.size() && i < N; i++) begin
      exp = {a_mem[i], i == 0, i == N - 1};
      n_checks++;
      if (a_q[i] !== exp) begin
        n_fail++;
        $display("FAIL wait_word%0d: got %h want %h", i, a_q[i], exp);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int k;
    logic [9:0] exp;
    fill_a_random();
    clear_a();
    a_dv = 1'b1;
    a_mr = 1'b1;
    pulse_a();
    repeat (4) step();
    pulse_a();
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    repeat (20) step();
    n_checks++;
    if (a_q.size() != N || a_fdone != 1 || a_issued != N) begin
      n_fail++;
      $display("FAIL restart_ignored: words %0d done %0d reads %0d want %0d 1 %0d",
               a_q.size(), a_fdone, a_issued, N, N);
    end
    fill_a_random();
    clear_a();
    pulse_a();
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    n_checks++;
    if (a_q.size() != N || a_fdone != 1) begin
      n_fail++;
      $display("FAIL restart_new: words %0d done %0d want %0d 1", a_q.size(), a_fdone, N);
    end
    for (int i = 0; i < a_q.size() && i < N; i++) begin
      exp = {a_mem[i], i == 0, i == N - 1};
      n_checks++;
      if (a_q[i] !== exp) begin
        n_fail++;
        $display("FAIL restart_word%0d: got %h want %h", i, a_q[i], exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    logic [9:0] exp;
    fill_a_random();
    clear_a();
    a_dv = 1'b1;
    a_mr = 1'b1;
    pulse_a();
    k = 0;
    while (a_q.size() < 3 && k < 100) begin step(); k++; end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_mv, a_cdo, a_busy, a_fd, a_mf, a_ml, a_md, a_adb} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h want 0",
               {a_mv, a_cdo, a_busy, a_fd, a_mf, a_ml, a_md, a_adb});
    end
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    n_checks++;
    if (a_fdone != 0 || a_mv !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abandon: done %0d valid %b want 0 0", a_fdone, a_mv);
    end
    clear_a();
    pulse_a();
    k = 0;
    while (a_fdone == 0 && k < 200) begin step(); k++; end
    n_checks++;
    if (a_q.size() != N || a_fdone != 1) begin
      n_fail++;
      $display("FAIL midrst_count: words %0d done %0d want %0d 1", a_q.size(), a_fdone, N);
    end
    for (int i = 0; i < a_q.size() && i < N; i++) begin
      exp = {a_mem[i], i == 0, i == N - 1};
      n_checks++;
      if (a_q[i] !== exp) begin
        n_fail++;
        $display("FAIL midrst_word%0d: got %h want %h", i, a_q[i], exp);
      end
    end
  endtask

  task automatic test_random_ready();
    int k;
    logic [9:0] exp;
    b_dv = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) b_mem[i] = 8'($urandom);
      clear_b();
      b_mr = 1'($urandom_range(0, 1));
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      k = 0;
      while (b_fdone == 0 && k < 400) begin
        b_mr = 1'($urandom_range(0, 1));
        step();
        k++;
      end
      b_mr = 1'b1;
      repeat (3) step();
      n_checks++;
      if (b_q.size() != N || b_fdone != 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: words %0d done %0d want %0d 1", f, b_q.size(), b_fdone, N);
      end
      n_checks++;
      if (b_max_out > 3) begin
        n_fail++;
        $display("FAIL rand%0d_credit: outstanding %0d want <= 3", f, b_max_out);
      end
      n_checks++;
      if (b_first_mv - b_first_cdo != 3) begin
        n_fail++;
        $display("FAIL rand%0d_latency: got %0d want 3", f, b_first_mv - b_first_cdo);
      end
      for (int i = 0; i < b_q.size() && i < N; i++) begin
        exp = {b_mem[i], i == 0, i == N - 1};
        n_checks++;
        if (b_q[i] !== exp) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: got %h want %h", f, i, b_q[i], exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_dv = 1'b0; a_mr = 1'b0;
    b_start = 1'b0; b_dv = 1'b0; b_mr = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 8'h00;
      b_mem[i] = 8'h00;
    end
    clear_a();
    clear_b();
    test_reset();
    test_basic();
    test_backpressure();
    test_wait_valid();
    test_restart_ignored();
    test_reset_midframe();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
